// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter and sequencer in front of the single-port
// `ram` block. Port 0 is the data-access path, port 1 the instruction-fetch
// path. One access is in flight at a time: IDLE picks a winner, ISSUE drives
// a one-cycle read or write strobe, WAIT holds until the matching ready flag
// (or a watchdog timeout), then the winner gets a one-cycle ack.
//
// Optional build macro: RAM_ARB_RR_EN
//   defined   -> round-robin tie break with a 1-bit preferred-port pointer
//   undefined -> fixed priority, port 0 wins ties
//
// Parameters:
//   ADDR_W   address width (matches `ram` size_addr)
//   TIMEOUT  WAIT cycles allowed before the access is aborted (1..15)
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pN_req/we/addr/wdata  port N request, held until pN_ack
//   pN_ack/err/rdata      one-cycle completion, timeout flag, read data
//   ram_read/ram_write    one-cycle strobes to `ram`
//   ram_address/data_in   address and write data to `ram`
//   ram_data_out          read data from `ram`
//   ram_ready_r/_w        read/write ready flags from `ram`
//   busy                  high while in ISSUE or WAIT
module ram_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [7:0]        p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [7:0]        p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [7:0]        p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [7:0]        p1_rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_data_in,
    input  logic [7:0]        ram_data_out,
    input  logic              ram_ready_r,
    input  logic              ram_ready_w,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Last WAIT count value before the watchdog fires.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              op_we_q, op_we_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ram_read_q, ram_read_d;
    logic              ram_write_q, ram_write_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [7:0]        ram_data_in_q, ram_data_in_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p0_err_q, p0_err_d;
    logic [7:0]        p0_rdata_q, p0_rdata_d;
    logic              p1_ack_q, p1_ack_d;
    logic              p1_err_q, p1_err_d;
    logic [7:0]        p1_rdata_q, p1_rdata_d;
    logic              busy_q, busy_d;
`ifdef RAM_ARB_RR_EN
    logic              rr_ptr_q, rr_ptr_d;
`endif

    logic elig0, elig1, win1, ready_hit;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        owner_d       = owner_q;
        op_we_d       = op_we_q;
        cnt_d         = cnt_q;
        ram_address_d = ram_address_q;
        ram_data_in_d = ram_data_in_q;
        p0_rdata_d    = p0_rdata_q;
        p1_rdata_d    = p1_rdata_q;
        ram_read_d    = 1'b0;
        ram_write_d   = 1'b0;
        p0_ack_d      = 1'b0;
        p0_err_d      = 1'b0;
        p1_ack_d      = 1'b0;
        p1_err_d      = 1'b0;
`ifdef RAM_ARB_RR_EN
        rr_ptr_d      = rr_ptr_q;
`endif

        // A port in its ack cycle is not eligible, so a held req is not
        // granted a second time on the back of the same access.
        elig0 = p0_req & ~p0_ack_q;
        elig1 = p1_req & ~p1_ack_q;
`ifdef RAM_ARB_RR_EN
        win1  = elig1 & (~elig0 | rr_ptr_q);
`else
        win1  = elig1 & ~elig0;
`endif
        // Only the flag matching the latched op counts.
        ready_hit = op_we_q ? ram_ready_w : ram_ready_r;

        case (state_q)
            ST_IDLE: begin
                if (elig0 | elig1) begin
                    owner_d       = win1;
                    op_we_d       = win1 ? p1_we    : p0_we;
                    ram_address_d = win1 ? p1_addr  : p0_addr;
                    ram_data_in_d = win1 ? p1_wdata : p0_wdata;
                    ram_read_d    = ~op_we_d;
                    ram_write_d   = op_we_d;
                    state_d       = ST_ISSUE;
`ifdef RAM_ARB_RR_EN
                    rr_ptr_d      = ~win1;
`endif
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ready_hit || cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        p1_ack_d = 1'b1;
                        p1_err_d = ~ready_hit;
                        if (ready_hit && !op_we_q) p1_rdata_d = ram_data_out;
                    end else begin
                        p0_ack_d = 1'b1;
                        p0_err_d = ~ready_hit;
                        if (ready_hit && !op_we_q) p0_rdata_d = ram_data_out;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values and simulation ordering cannot matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            op_we_q       <= 1'b0;
            cnt_q         <= '0;
            ram_read_q    <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_address_q <= '0;
            ram_data_in_q <= '0;
            p0_ack_q      <= 1'b0;
            p0_err_q      <= 1'b0;
            p0_rdata_q    <= '0;
            p1_ack_q      <= 1'b0;
            p1_err_q      <= 1'b0;
            p1_rdata_q    <= '0;
            busy_q        <= 1'b0;
`ifdef RAM_ARB_RR_EN
            rr_ptr_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            op_we_q       <= op_we_d;
            cnt_q         <= cnt_d;
            ram_read_q    <= ram_read_d;
            ram_write_q   <= ram_write_d;
            ram_address_q <= ram_address_d;
            ram_data_in_q <= ram_data_in_d;
            p0_ack_q      <= p0_ack_d;
            p0_err_q      <= p0_err_d;
            p0_rdata_q    <= p0_rdata_d;
            p1_ack_q      <= p1_ack_d;
            p1_err_q      <= p1_err_d;
            p1_rdata_q    <= p1_rdata_d;
            busy_q        <= busy_d;
`ifdef RAM_ARB_RR_EN
            rr_ptr_q      <= rr_ptr_d;
`endif
        end
    end

    assign ram_read    = ram_read_q;
    assign ram_write   = ram_write_q;
    assign ram_address = ram_address_q;
    assign ram_data_in = ram_data_in_q;
    assign p0_ack      = p0_ack_q;
    assign p0_err      = p0_err_q;
    assign p0_rdata    = p0_rdata_q;
    assign p1_ack      = p1_ack_q;
    assign p1_err      = p1_err_q;
    assign p1_rdata    = p1_rdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a transaction-level `ram` responder,
// a table of single accesses, hand-written multi-cycle sequences and a
// randomized phase checked against a transaction-level reference model.
module tb_ram_arbiter;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 4;
    localparam int NO_RDY  = 99;

    logic       clk = 1'b0;
    logic       reset;
    logic       p0_req, p0_we, p0_ack, p0_err;
    logic [7:0] p0_addr, p0_wdata, p0_rdata;
    logic       p1_req, p1_we, p1_ack, p1_err;
    logic [7:0] p1_addr, p1_wdata, p1_rdata;
    logic       ram_read, ram_write, ram_ready_r, ram_ready_w, busy;
    logic [7:0] ram_address, ram_data_in, ram_data_out;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_ready_r(ram_ready_r), .ram_ready_w(ram_ready_w), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- ram responder ----------------
    logic [7:0] mem [0:255];
    int         rsp_cnt = 0;
    int         rsp_delay = 0;
    int         rsp_cur_delay = 0;
    logic       rsp_op_w = 1'b0;
    logic [7:0] rsp_data = 8'h00;
    logic       force_r = 1'b0;
    logic       force_w = 1'b0;
    int         cyc = 0;

    // Advance one clock; inputs are updated 1 time unit after the edge.
    // A strobe seen in a cycle makes the matching ready rise rsp_delay
    // cycles into the following WAIT period.
    task automatic tick();
        logic mr, mw;
        @(posedge clk);
        #1;
        cyc++;
        mr = 1'b0;
        mw = 1'b0;
        if (reset) begin
            rsp_cnt = 0;
        end else if (ram_read || ram_write) begin
            rsp_cnt       = rsp_delay + 1;
            rsp_cur_delay = rsp_delay;
            rsp_op_w      = ram_write;
            if (ram_write) mem[ram_address] = ram_data_in;
            else           rsp_data = mem[ram_address];
        end else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                if (rsp_op_w) mw = 1'b1;
                else begin
                    mr = 1'b1;
                    ram_data_out = rsp_data;
                end
            end
        end
        ram_ready_r = mr | force_r;
        ram_ready_w = mw | force_w;
    endtask

    task automatic drive(input int p, input logic r, input logic we,
                         input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ctl"}, 32'({ram_read, ram_write, p0_ack, p0_err, p1_ack, p1_err, busy}), 0);
        check({tag, " ram_address"}, 32'(ram_address), 0);
        check({tag, " ram_data_in"}, 32'(ram_data_in), 0);
        check({tag, " p0_rdata"}, 32'(p0_rdata), 0);
        check({tag, " p1_rdata"}, 32'(p1_rdata), 0);
    endtask

    // ---------------- single access ----------------
    typedef struct {
        int         port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         delay;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         exp_lat;   // cycles from grant edge to ack cycle
        bit         drop;      // drop req and scramble fields after grant
    } vec_t;

    task automatic run_one(input vec_t v, input string tag);
        int         lat, n_strobe;
        bit         done, other;
        logic       s_we, e;
        logic [7:0] s_addr, s_data, r;
        lat = 0; n_strobe = 0; done = 0; other = 0;
        s_we = 0; s_addr = 0; s_data = 0; e = 0; r = 0;
        rsp_delay = v.delay;
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (lat == 1 && v.drop) drive(v.port, 1'b0, ~v.we, ~v.addr, ~v.wdata);
            if (ram_read || ram_write) begin
                n_strobe++;
                s_we = ram_write; s_addr = ram_address; s_data = ram_data_in;
            end
            if ((v.port == 0) ? p1_ack : p0_ack) other = 1;
            if ((v.port == 0) ? p0_ack : p1_ack) begin
                done = 1;
                e = (v.port == 0) ? p0_err : p1_err;
                r = (v.port == 0) ? p0_rdata : p1_rdata;
            end
        end
        drive(v.port, 1'b0, v.we, v.addr, v.wdata);
        check({tag, " ack seen"}, 32'(done), 1);
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " err"}, 32'(e), 32'(v.exp_err));
        check({tag, " rdata"}, 32'(r), 32'(v.exp_rdata));
        check({tag, " strobe count"}, n_strobe, 1);
        check({tag, " strobe op"}, 32'(s_we), 32'(v.we));
        check({tag, " ram_address"}, 32'(s_addr), 32'(v.addr));
        if (v.we) check({tag, " ram_data_in"}, 32'(s_data), 32'(v.wdata));
        check({tag, " other ack"}, 32'(other), 0);
        tick();
        check({tag, " ack pulse"}, 32'({p0_ack, p0_err, p1_ack, p1_err}), 0);
    endtask

    // ---------------- simultaneous pair ----------------
    task automatic run_pair(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                            input int first, input logic [7:0] exp0, input logic [7:0] exp1);
        int         t0, t1;
        logic [7:0] r0, r1;
        t0 = -1; t1 = -1; r0 = 0; r1 = 0;
        rsp_delay = 0;
        drive(0, 1'b1, 1'b0, a0, 8'h00);
        drive(1, 1'b1, 1'b0, a1, 8'h00);
        for (int i = 1; i <= 30 && (t0 < 0 || t1 < 0); i++) begin
            tick();
            if (p0_ack && t0 < 0) begin t0 = i; r0 = p0_rdata; drive(0, 1'b0, 1'b0, a0, 8'h00); end
            if (p1_ack && t1 < 0) begin t1 = i; r1 = p1_rdata; drive(1, 1'b0, 1'b0, a1, 8'h00); end
        end
        drive(0, 1'b0, 1'b0, a0, 8'h00);
        drive(1, 1'b0, 1'b0, a1, 8'h00);
        check({tag, " first ack cycle"}, (first == 0) ? t0 : t1, 3);
        check({tag, " second ack cycle"}, (first == 0) ? t1 : t0, 6);
        check({tag, " p0_rdata"}, 32'(r0), 32'(exp0));
        check({tag, " p1_rdata"}, 32'(r1), 32'(exp1));
        tick();
    endtask

    // ---------------- ready mismatch ----------------
    task automatic run_mismatch(input string tag, input bit give_w, input logic [7:0] a,
                                input logic [7:0] d, input int exp_t, input logic exp_err);
        int   t, n_ack;
        logic e;
        t = -1; n_ack = 0; e = 0;
        rsp_delay = NO_RDY;
        force_r = 1'b1;
        drive(0, 1'b1, 1'b1, a, d);
        for (int i = 1; i <= 12; i++) begin
            force_w = give_w && (i == 4);
            tick();
            if (p0_ack) begin
                n_ack++;
                if (t < 0) begin t = i; e = p0_err; end
                drive(0, 1'b0, 1'b1, a, d);
            end
        end
        force_r = 1'b0;
        force_w = 1'b0;
        check({tag, " ack cycle"}, t, exp_t);
        check({tag, " err"}, 32'(e), 32'(exp_err));
        check({tag, " ack count"}, n_ack, 1);
        tick();
    endtask

    // ---------------- randomized phase ----------------
    task automatic run_random(input int ncyc, input logic [7:0] rd0, input logic [7:0] rd1, input bit pref_init);
        bit         pend [2], granted [2], elig_prev [2], exp_err [2];
        logic       we_r [2];
        logic [7:0] addr_r [2], wd_r [2], exp_rd [2], next_rd [2], na;
        int         strobe_cyc [2], exp_lat [2], wait_cnt [2];
        bit         pref, inflight, ack, err;
        logic [7:0] rdata;
        int         w, d;
        pref = pref_init; inflight = 0;
        exp_rd[0] = rd0; exp_rd[1] = rd1;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; granted[p] = 0; elig_prev[p] = 0; exp_err[p] = 0;
            we_r[p] = 0; addr_r[p] = 0; wd_r[p] = 0; next_rd[p] = 0;
            strobe_cyc[p] = 0; exp_lat[p] = 0; wait_cnt[p] = 0;
        end
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (ram_read || ram_write) begin
                w = int'(ram_address[7]);
                d = rsp_cur_delay;
                check("rnd strobe from pending port", 32'(pend[w] && !granted[w]), 1);
                if (elig_prev[0] && elig_prev[1]) check("rnd tie winner", w, 32'(pref));
                check("rnd strobe op", 32'({ram_read, ram_write}), 32'({!we_r[w], we_r[w]}));
                check("rnd strobe addr", 32'(ram_address), 32'(addr_r[w]));
                if (we_r[w]) check("rnd strobe wdata", 32'(ram_data_in), 32'(wd_r[w]));
                granted[w]    = 1;
                strobe_cyc[w] = cyc;
                exp_lat[w]    = (d < TIMEOUT) ? 2 + d : 1 + TIMEOUT;
                exp_err[w]    = (d >= TIMEOUT);
                next_rd[w]    = (!we_r[w] && d < TIMEOUT) ? mem[ram_address] : exp_rd[w];
                inflight      = 1;
`ifdef RAM_ARB_RR_EN
                pref = (w == 0);
`endif
            end
            for (int p = 0; p < 2; p++) begin
                ack   = (p == 0) ? p0_ack : p1_ack;
                err   = (p == 0) ? p0_err : p1_err;
                rdata = (p == 0) ? p0_rdata : p1_rdata;
                if (ack) begin
                    check("rnd ack for granted port", 32'(pend[p] && granted[p]), 1);
                    check("rnd ack latency", cyc - strobe_cyc[p], exp_lat[p]);
                    check("rnd ack err", 32'(err), 32'(exp_err[p]));
                    check("rnd ack rdata", 32'(rdata), 32'(next_rd[p]));
                    exp_rd[p] = next_rd[p];
                    pend[p] = 0; granted[p] = 0; inflight = 0;
                end else begin
                    check("rnd err without ack", 32'(err), 0);
                    check("rnd rdata hold", 32'(rdata), 32'(exp_rd[p]));
                end
                if (pend[p]) begin
                    wait_cnt[p]++;
                    if (wait_cnt[p] > 60) begin
                        check("rnd wait bound", wait_cnt[p], 60);
                        pend[p] = 0; granted[p] = 0; inflight = 0;
                    end
                end
            end
            check("rnd busy", 32'(busy), 32'(inflight));
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        na = 8'($urandom_range(0, 127));
                        na[7] = (p == 1);
                        pend[p] = 1; granted[p] = 0; wait_cnt[p] = 0;
                        we_r[p] = 1'($urandom_range(0, 1));
                        addr_r[p] = na;
                        wd_r[p] = 8'($urandom_range(0, 255));
                        drive(p, 1'b1, we_r[p], addr_r[p], wd_r[p]);
                    end else begin
                        drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
                    end
                end else if (granted[p] && $urandom_range(0, 3) == 0) begin
                    drive(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                end
            end
            elig_prev[0] = p0_req && !p0_ack;
            elig_prev[1] = p1_req && !p1_ack;
            rsp_delay = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(0, TIMEOUT + 1));
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs [12];
    int   n_ack_after_rst;
    bit   rr_pref;

    initial begin
        vecs[0]  = '{0, 1'b1, 8'h10, 8'hA5, 0,         1'b0, 8'h00, 3,           1'b0};
        vecs[1]  = '{0, 1'b0, 8'h10, 8'h00, 0,         1'b0, 8'hA5, 3,           1'b1};
        vecs[2]  = '{1, 1'b0, 8'h7F, 8'h00, 0,         1'b0, 8'h00, 3,           1'b0};
        vecs[3]  = '{1, 1'b1, 8'h85, 8'h3C, 2,         1'b0, 8'h00, 5,           1'b1};
        vecs[4]  = '{1, 1'b0, 8'h85, 8'h00, 1,         1'b0, 8'h3C, 4,           1'b0};
        vecs[5]  = '{0, 1'b0, 8'h20, 8'h00, NO_RDY,    1'b1, 8'hA5, 2 + TIMEOUT, 1'b0};
        vecs[6]  = '{0, 1'b1, 8'h20, 8'h5A, TIMEOUT-1, 1'b0, 8'hA5, 2 + TIMEOUT, 1'b0};
        vecs[7]  = '{0, 1'b0, 8'h20, 8'h00, 0,         1'b0, 8'h5A, 3,           1'b0};
        vecs[8]  = '{1, 1'b1, 8'h7F, 8'hFF, NO_RDY,    1'b1, 8'h3C, 2 + TIMEOUT, 1'b0};
        vecs[9]  = '{1, 1'b0, 8'h7F, 8'h00, 0,         1'b0, 8'hFF, 3,           1'b0};
        vecs[10] = '{0, 1'b0, 8'h00, 8'h00, TIMEOUT,   1'b1, 8'h5A, 2 + TIMEOUT, 1'b0};
        vecs[11] = '{0, 1'b0, 8'h10, 8'h00, 0,         1'b0, 8'hA5, 3,           1'b0};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        ram_data_out = 8'h00;
        ram_ready_r  = 1'b0;
        ram_ready_w  = 1'b0;
        tick();
        tick();
        check_zero("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) run_one(vecs[i], $sformatf("vec%0d", i));

`ifdef RAM_ARB_RR_EN
        // Last grant was port 0, so the pointer prefers port 1.
        run_pair("pair1", 8'h10, 8'h85, 1, 8'hA5, 8'h3C);
`else
        run_pair("pair1", 8'h10, 8'h85, 0, 8'hA5, 8'h3C);
`endif
        run_one('{1, 1'b0, 8'h7F, 8'h00, 0, 1'b0, 8'hFF, 3, 1'b0}, "p1 single");
        // After a port 1 grant both modes prefer port 0.
        run_pair("pair2", 8'h20, 8'h7F, 0, 8'h5A, 8'hFF);

        run_mismatch("mismatch then ready_w", 1'b1, 8'h30, 8'h77, 5, 1'b0);
        run_mismatch("mismatch to timeout", 1'b0, 8'h31, 8'h78, 2 + TIMEOUT, 1'b1);

        // Reset during WAIT of a port 1 read.
        rsp_delay = NO_RDY;
        drive(1, 1'b1, 1'b0, 8'h85, 8'h00);
        repeat (3) tick();
        check("rst busy in WAIT", 32'(busy), 1);
        reset = 1'b1;
        drive(1, 1'b0, 1'b0, 8'h85, 8'h00);
        tick();
        check_zero("reset mid-op");
        reset = 1'b0;
        n_ack_after_rst = 0;
        repeat (8) begin
            tick();
            if (p0_ack || p1_ack) n_ack_after_rst++;
        end
        check("rst dropped access acks", n_ack_after_rst, 0);
        run_one('{0, 1'b0, 8'h10, 8'h00, 0, 1'b0, 8'hA5, 3, 1'b0}, "post-reset p0");

`ifdef RAM_ARB_RR_EN
        rr_pref = 1'b1;
`else
        rr_pref = 1'b0;
`endif
        run_random(3000, 8'hA5, 8'h00, rr_pref);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global time limit: simulation did not finish");
        $fatal(1);
    end

endmodule
